digit_counter_bank: RTL and testbench

Parametrised multi-digit counter core for the advanced counter family, generalising the per-digit counters, mode selection and carry lanes into one block. Radix and digit count are set by parameters. Per-digit step pulses ripple carries or borrows within a single cycle. The block adds saturating mode, a synchronous clear, a full-counter wrap pulse and an at-limit flag. It sits between the input synchroniser/trigger stage and the 7-segment decode/shift stage.

---
 rtl/digit_counter_bank.sv | 124 ++++++++++++
 tb/tb_digit_counter_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/digit_counter_bank.sv
// digit_counter_bank
// Multi-digit up/down counter with a per-digit step request, a single-cycle
// combinational carry/borrow ripple, optional saturation, a loadable
// per-digit limit register, a synchronous clear, a registered full-counter
// wrap pulse and a combinational at-limit flag.
module digit_counter_bank #(
    parameter int DIGITS = 4,
    parameter int RADIX  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS-1:0]     inc,
    input  logic                  up_down_sel,
    input  logic                  carry_en,
    input  logic                  limit_en,
    input  logic                  sat_en,
    input  logic                  limit_load,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   cnt_out,
    output logic [4*DIGITS-1:0]   limit_out,
    output logic                  wrap_out,
    output logic                  at_limit
);

    localparam int              W           = 4 * DIGITS;
    localparam logic [3:0]      TOP_DIGIT   = 4'(RADIX - 1);
    localparam logic [W-1:0]    LIMIT_RESET = {DIGITS{TOP_DIGIT}};

    // Unsupported radix or digit count must stop elaboration.
    if (RADIX < 2 || RADIX > 16) begin : g_radix_check
        $error("digit_counter_bank: RADIX must be in 2..16");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_digits_check
        $error("digit_counter_bank: DIGITS must be in 1..8");
    end

    logic [W-1:0] cnt_q;
    logic [W-1:0] limit_q;
    logic         wrap_q;

    logic [W-1:0] cnt_next;
    logic         carry_top;
    logic         all_at_max;

    logic [3:0]   digit;
    logic [3:0]   digit_max;
    logic [3:0]   digit_new;
    logic         step;
    logic         carry;

    // Next count for every digit, rippling carry/borrow from digit 0 upward,
    // plus the at-limit reduction over the registered count and limit.
    always_comb begin
        cnt_next   = cnt_q;
        carry      = 1'b0;
        all_at_max = 1'b1;
        digit      = 4'd0;
        digit_max  = 4'd0;
        digit_new  = 4'd0;
        step       = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            digit     = cnt_q[4*j +: 4];
            digit_max = limit_en ? limit_q[4*j +: 4] : TOP_DIGIT;
            step      = inc[j] | (carry_en & carry);
            carry     = 1'b0;
            digit_new = digit;
            if (step) begin
                if (!up_down_sel) begin
                    if (digit >= digit_max) begin
                        if (sat_en) begin
                            digit_new = digit_max;
                        end else begin
                            digit_new = 4'd0;
                            carry     = 1'b1;
                        end
                    end else begin
                        digit_new = digit + 4'd1;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        if (!sat_en) begin
                            digit_new = digit_max;
                            carry     = 1'b1;
                        end
                    end else if (digit > digit_max) begin
                        digit_new = digit_max;
                    end else begin
                        digit_new = digit - 4'd1;
                    end
                end
            end
            cnt_next[4*j +: 4] = digit_new;
            all_at_max = all_at_max & (digit == digit_max);
        end
        carry_top = carry;
    end

    // Count, limit and wrap registers; limit capture sees the old count
    // even when clear or stepping happen in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            limit_q <= LIMIT_RESET;
            wrap_q  <= 1'b0;
        end else begin
            if (limit_load) begin
                limit_q <= cnt_q;
            end
            if (clear) begin
                cnt_q  <= '0;
                wrap_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_next;
                wrap_q <= carry_top;
            end
        end
    end

    assign cnt_out   = cnt_q;
    assign limit_out = limit_q;
    assign wrap_out  = wrap_q;
    assign at_limit  = all_at_max;

endmodule

// File: tb/tb_digit_counter_bank.sv
// tb_digit_counter_bank
// Directed walk through the counter's main scenarios followed by a
// randomized phase, all checked against an array-based digit model.
module tb_digit_counter_bank;

    localparam int DIGITS = 4;
    localparam int RADIX  = 10;

    logic                 clk;
    logic                 reset;
    logic [DIGITS-1:0]    inc;
    logic                 up_down_sel;
    logic                 carry_en;
    logic                 limit_en;
    logic                 sat_en;
    logic                 limit_load;
    logic                 clear;
    logic [4*DIGITS-1:0]  cnt_out;
    logic [4*DIGITS-1:0]  limit_out;
    logic                 wrap_out;
    logic                 at_limit;

    int tests_run;
    int fail_count;

    int   m_cnt[DIGITS];
    int   m_lim[DIGITS];
    logic m_wrap;

    digit_counter_bank #(.DIGITS(DIGITS), .RADIX(RADIX)) dut (
        .clk         (clk),
        .reset       (reset),
        .inc         (inc),
        .up_down_sel (up_down_sel),
        .carry_en    (carry_en),
        .limit_en    (limit_en),
        .sat_en      (sat_en),
        .limit_load  (limit_load),
        .clear       (clear),
        .cnt_out     (cnt_out),
        .limit_out   (limit_out),
        .wrap_out    (wrap_out),
        .at_limit    (at_limit)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic resetModel();
        for (int j = 0; j < DIGITS; j++) begin
            m_cnt[j] = 0;
            m_lim[j] = RADIX - 1;
        end
        m_wrap = 1'b0;
    endtask

    // One clock edge of the counter, computed digit by digit from the
    // counting rules using the inputs that were present before the edge.
    task automatic modelStep();
        int  old_cnt[DIGITS];
        int  old_lim[DIGITS];
        bit  c;
        bit  s;
        int  mx;
        old_cnt = m_cnt;
        old_lim = m_lim;
        if (limit_load) m_lim = old_cnt;
        if (clear) begin
            for (int j = 0; j < DIGITS; j++) m_cnt[j] = 0;
            m_wrap = 1'b0;
        end else begin
            c = 1'b0;
            for (int j = 0; j < DIGITS; j++) begin
                mx = limit_en ? old_lim[j] : RADIX - 1;
                s  = inc[j] || (carry_en && c);
                c  = 1'b0;
                if (s && !up_down_sel) begin
                    if (old_cnt[j] < mx) m_cnt[j] = old_cnt[j] + 1;
                    else if (sat_en)     m_cnt[j] = mx;
                    else begin           m_cnt[j] = 0; c = 1'b1; end
                end else if (s) begin
                    if (old_cnt[j] == 0) begin
                        if (!sat_en) begin m_cnt[j] = mx; c = 1'b1; end
                    end else if (old_cnt[j] > mx) m_cnt[j] = mx;
                    else m_cnt[j] = old_cnt[j] - 1;
                end
            end
            m_wrap = c;
        end
    endtask

    function automatic logic [4*DIGITS-1:0] packDigits(input int d[DIGITS]);
        logic [4*DIGITS-1:0] v;
        v = '0;
        for (int j = 0; j < DIGITS; j++) v[4*j +: 4] = 4'(d[j]);
        return v;
    endfunction

    function automatic logic modelAtLimit();
        logic r;
        r = 1'b1;
        for (int j = 0; j < DIGITS; j++)
            if (m_cnt[j] != (limit_en ? m_lim[j] : RADIX - 1)) r = 1'b0;
        return r;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic checkOutput(input string tag);
        checkValue({tag, ".cnt"},   32'(cnt_out),   32'(packDigits(m_cnt)));
        checkValue({tag, ".limit"}, 32'(limit_out), 32'(packDigits(m_lim)));
        checkValue({tag, ".wrap"},  32'(wrap_out),  32'(m_wrap));
        checkValue({tag, ".atlim"}, 32'(at_limit),  32'(modelAtLimit()));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, check.
    task automatic applyStimulus(input string tag, input logic [DIGITS-1:0] i_inc,
                                 input logic ud, input logic ce, input logic le,
                                 input logic se, input logic ld, input logic clr);
        inc         = i_inc;
        up_down_sel = ud;
        carry_en    = ce;
        limit_en    = le;
        sat_en      = se;
        limit_load  = ld;
        clear       = clr;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        tests_run   = 0;
        fail_count  = 0;
        clk         = 1'b0;
        reset       = 1'b1;
        inc         = '0;
        up_down_sel = 1'b0;
        carry_en    = 1'b0;
        limit_en    = 1'b0;
        sat_en      = 1'b0;
        limit_load  = 1'b0;
        clear       = 1'b0;
        resetModel();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkValue("rst.cnt",   32'(cnt_out),   32'h0000);
        checkValue("rst.limit", 32'(limit_out), 32'h9999);
        checkValue("rst.wrap",  32'(wrap_out),  32'h0);
        checkValue("rst.atlim", 32'(at_limit),  32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Ten up pulses on digit 0 with carry
        for (int k = 0; k < 10; k++) applyStimulus("up10", 4'b0001, 0, 1, 0, 0, 0, 0);
        checkValue("up10.cnt",   32'(cnt_out),   32'h0010);
        checkValue("up10.limit", 32'(limit_out), 32'h9999);

        // Full borrow from zero
        applyStimulus("clr1", 4'b0000, 0, 1, 0, 0, 0, 1);
        applyStimulus("borrow", 4'b0001, 1, 1, 0, 0, 0, 0);
        checkValue("borrow.cnt",  32'(cnt_out),  32'h9999);
        checkValue("borrow.wrap", 32'(wrap_out), 32'h1);
        applyStimulus("idle", 4'b0000, 1, 1, 0, 0, 0, 0);
        checkValue("idle.wrap", 32'(wrap_out), 32'h0);

        // Limit capture together with clear, then count with limits
        applyStimulus("clr2", 4'b0000, 0, 1, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) applyStimulus("to305", 4'b0100, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) applyStimulus("to305", 4'b0001, 0, 1, 0, 0, 0, 0);
        checkValue("to305.cnt", 32'(cnt_out), 32'h0305);
        applyStimulus("ldclr", 4'b0000, 0, 1, 0, 0, 1, 1);
        checkValue("ldclr.limit", 32'(limit_out), 32'h0305);
        checkValue("ldclr.cnt",   32'(cnt_out),   32'h0000);
        for (int k = 0; k < 6; k++) applyStimulus("lim6", 4'b0001, 0, 1, 1, 0, 0, 0);
        checkValue("lim6.cnt", 32'(cnt_out), 32'h0100);

        // Saturation at the digit maximum
        applyStimulus("clr3", 4'b0000, 0, 1, 0, 0, 0, 1);
        for (int k = 0; k < 9; k++) applyStimulus("to9", 4'b0001, 0, 1, 0, 0, 0, 0);
        applyStimulus("satup", 4'b0001, 0, 1, 0, 1, 0, 0);
        checkValue("satup.cnt",  32'(cnt_out),  32'h0009);
        checkValue("satup.wrap", 32'(wrap_out), 32'h0);
        applyStimulus("satdn", 4'b0001, 1, 1, 0, 1, 0, 0);
        checkValue("satdn.cnt", 32'(cnt_out), 32'h0008);

        // Direct and carried step on one digit collapse to one step
        applyStimulus("to9b", 4'b0001, 0, 1, 0, 0, 0, 0);
        applyStimulus("dual", 4'b0011, 0, 1, 0, 0, 0, 0);
        checkValue("dual.cnt", 32'(cnt_out), 32'h0010);
        applyStimulus("clrinc", 4'b0001, 0, 1, 0, 0, 0, 1);
        checkValue("clrinc.cnt", 32'(cnt_out), 32'h0000);

        // Asynchronous reset mid-count
        applyStimulus("to1234", 4'b1000, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) applyStimulus("to1234", 4'b0100, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) applyStimulus("to1234", 4'b0010, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus("to1234", 4'b0001, 0, 1, 0, 0, 0, 0);
        checkValue("to1234.cnt", 32'(cnt_out), 32'h1234);
        inc = '0;
        #2;
        reset = 1'b1;
        #1;
        checkValue("arst.cnt",   32'(cnt_out),   32'h0000);
        checkValue("arst.limit", 32'(limit_out), 32'h9999);
        checkValue("arst.wrap",  32'(wrap_out),  32'h0);
        resetModel();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("first", 4'b0001, 0, 1, 0, 0, 0, 0);
        checkValue("first.cnt", 32'(cnt_out), 32'h0001);

        // Randomized modes, steps, loads and clears
        for (int k = 0; k < 400; k++) begin
            applyStimulus("rand", 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 24) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
